// File: rtl/mccomp_dbg_pkg.sv
// Shared encodings for the mccomp run/debug controller: main FSM states,
// scan sub-FSM phases and halt-cause codes.
package mccomp_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_RUN      = 3'd2,
        ST_SCAN_SEL = 3'd3,
        ST_SCAN_OUT = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SC_IDLE = 2'd0,
        SC_SEL  = 2'd1,
        SC_OUT  = 2'd2
    } scan_ph_t;

    localparam logic [1:0] HC_NONE  = 2'd0;
    localparam logic [1:0] HC_MAX   = 2'd1;
    localparam logic [1:0] HC_BP    = 2'd2;
    localparam logic [1:0] HC_ABORT = 2'd3;

    function automatic logic is_busy(input state_t s);
        case (s)
            ST_RESET, ST_RUN, ST_SCAN_SEL, ST_SCAN_OUT: is_busy = 1'b1;
            default:                                    is_busy = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mccomp_dbg_scan.sv
// Register-file scanner: walks indices 0..NUM_REGS-1, one settle cycle per
// register, then presents {idx,value} on a valid/ready port until accepted.
module mccomp_dbg_scan
    import mccomp_dbg_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int SEL_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_go,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              dump_ready,
    output logic [SEL_W-1:0]  reg_sel,
    output logic              dump_valid,
    output logic [SEL_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              scan_done
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    scan_ph_t          ph_r;
    scan_ph_t          ph_next_s;
    logic [SEL_W-1:0]  sel_r;
    logic              valid_r;
    logic [SEL_W-1:0]  idx_r;
    logic [DATA_W-1:0] data_r;
    logic              hs_s;

    // reg_sel doubles as the scan index: it already equals idx during the settle cycle
    assign hs_s      = (ph_r == SC_OUT) && valid_r && dump_ready;
    assign scan_done = hs_s && (sel_r == LAST_IDX);

    assign reg_sel    = sel_r;
    assign dump_valid = valid_r;
    assign dump_idx   = idx_r;
    assign dump_data  = data_r;

    // Scan phase sequencing
    always_comb begin
        ph_next_s = ph_r;
        if (scan_go) begin
            ph_next_s = SC_SEL;
        end else begin
            case (ph_r)
                SC_IDLE: ph_next_s = SC_IDLE;
                SC_SEL:  ph_next_s = SC_OUT;
                SC_OUT: begin
                    if (hs_s) begin
                        ph_next_s = (sel_r == LAST_IDX) ? SC_IDLE : SC_SEL;
                    end else begin
                        ph_next_s = SC_OUT;
                    end
                end
                default: ph_next_s = SC_IDLE;
            endcase
        end
    end

    // Index, capture and beat registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_r    <= SC_IDLE;
            sel_r   <= {SEL_W{1'b0}};
            valid_r <= 1'b0;
            idx_r   <= {SEL_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
        end else begin
            ph_r <= ph_next_s;
            if (scan_go) begin
                sel_r   <= {SEL_W{1'b0}};
                valid_r <= 1'b0;
            end else if (ph_r == SC_SEL) begin
                valid_r <= 1'b1;
                idx_r   <= sel_r;
                data_r  <= reg_data;
            end else if (hs_s) begin
                valid_r <= 1'b0;
                if (sel_r != LAST_IDX) begin
                    sel_r <= sel_r + SEL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mccomp_dbg_ctrl.sv
// Run/debug controller for mccomp: timed CPU reset, gated run with cycle
// limit / breakpoint / abort halts, then a full register-file dump.
module mccomp_dbg_ctrl
    import mccomp_dbg_pkg::*;
#(
    parameter int RST_CYCLES = 3,
    parameter int NUM_REGS   = 32,
    parameter int SEL_W      = 5,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              cpu_rstn,
    output logic              cpu_run,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [SEL_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              busy,
    output logic              done,
    output logic [1:0]        halt_cause
);

    localparam int               RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_next_s;
    logic [RC_W-1:0]   rc_r;
    logic [CNT_W-1:0]  max_r;
    logic              bp_en_r;
    logic [ADDR_W-1:0] bp_addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        cause_r;
    logic [1:0]        cause_next_s;
    logic              cpu_rstn_r;
    logic              run_r;
    logic              busy_r;
    logic              done_r;
    logic              start_acc_s;
    logic              scan_go_s;
    logic              scan_done_s;
    logic              bp_hit_s;
    logic              lim_hit_s;
    logic              run_s;

    assign bp_hit_s  = bp_en_r && (cpu_pc == bp_addr_r);
    assign lim_hit_s = (max_r != {CNT_W{1'b0}}) && ((cnt_r + CNT_W'(1)) == max_r);
    // The clock enable drops in the very cycle the PC matches so the
    // breakpoint instruction never executes.
    assign run_s     = run_r && !bp_hit_s;

    assign cpu_rstn   = cpu_rstn_r;
    assign cpu_run    = run_s;
    assign cycle_cnt  = cnt_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign halt_cause = cause_r;

    // Main sequence: next state, halt cause and scan launch
    always_comb begin
        state_next_s = state_r;
        cause_next_s = cause_r;
        start_acc_s  = 1'b0;
        scan_go_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s = ST_RESET;
                    cause_next_s = HC_NONE;
                    start_acc_s  = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RESET: begin
                if (rc_r == RC_LAST) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_RESET;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next_s = ST_SCAN_SEL;
                    cause_next_s = HC_ABORT;
                    scan_go_s    = 1'b1;
                end else if (bp_hit_s) begin
                    state_next_s = ST_SCAN_SEL;
                    cause_next_s = HC_BP;
                    scan_go_s    = 1'b1;
                end else if (lim_hit_s) begin
                    state_next_s = ST_SCAN_SEL;
                    cause_next_s = HC_MAX;
                    scan_go_s    = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_SCAN_SEL: state_next_s = ST_SCAN_OUT;
            ST_SCAN_OUT: begin
                if (scan_done_s) begin
                    state_next_s = ST_DONE;
                end else if (dump_valid && dump_ready) begin
                    state_next_s = ST_SCAN_SEL;
                end else begin
                    state_next_s = ST_SCAN_OUT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State and state-decoded output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cause_r    <= HC_NONE;
            cpu_rstn_r <= 1'b0;
            run_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rc_r       <= {RC_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            cause_r    <= cause_next_s;
            cpu_rstn_r <= !((state_next_s == ST_IDLE) || (state_next_s == ST_RESET));
            run_r      <= (state_next_s == ST_RUN);
            busy_r     <= is_busy(state_next_s);
            done_r     <= (state_next_s == ST_DONE);
            if (state_r == ST_RESET) begin
                rc_r <= rc_r + RC_W'(1);
            end else begin
                rc_r <= {RC_W{1'b0}};
            end
        end
    end

    // Run parameters captured at start and the saturating run-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_r     <= {CNT_W{1'b0}};
            bp_en_r   <= 1'b0;
            bp_addr_r <= {ADDR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
        end else if (start_acc_s) begin
            max_r     <= max_cycles;
            bp_en_r   <= bp_en;
            bp_addr_r <= bp_addr;
            cnt_r     <= {CNT_W{1'b0}};
        end else if (run_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    mccomp_dbg_scan #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W),
        .DATA_W   (DATA_W)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .scan_go    (scan_go_s),
        .reg_data   (reg_data),
        .dump_ready (dump_ready),
        .reg_sel    (reg_sel),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .scan_done  (scan_done_s)
    );

endmodule

// File: tb/tb_mccomp_dbg_ctrl.sv
// Directed bench for mccomp_dbg_ctrl with a tiny CPU model (PC stepping by 4,
// register file as a pure function of a per-test seed and the select).
module tb_mccomp_dbg_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] max_cycles;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] cpu_pc;
    logic        cpu_rstn;
    logic        cpu_run;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic [31:0] cycle_cnt;
    logic        busy;
    logic        done;
    logic [1:0]  halt_cause;

    logic [7:0]  seed;
    int          n_cmp;
    int          n_bad;
    int          rstn_low;
    int          run_cyc;
    int          beats;
    int          stall_cnt;
    int          bp_seen;
    int          rst_hit;

    mccomp_dbg_ctrl #(
        .RST_CYCLES (3),
        .NUM_REGS   (32),
        .SEL_W      (5),
        .DATA_W     (32),
        .ADDR_W     (32),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .max_cycles (max_cycles),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .cpu_pc     (cpu_pc),
        .cpu_rstn   (cpu_rstn),
        .cpu_run    (cpu_run),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .cycle_cnt  (cycle_cnt),
        .busy       (busy),
        .done       (done),
        .halt_cause (halt_cause)
    );

    function automatic logic [31:0] reg_val(input logic [7:0] s, input logic [4:0] i);
        reg_val = {s, 3'b000, i, 16'h5A5A ^ {11'd0, i}};
    endfunction

    assign reg_data = reg_val(seed, reg_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cpu_rstn) begin
            cpu_pc <= 32'd0;
        end else if (cpu_run) begin
            cpu_pc <= cpu_pc + 32'd4;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_cpu_rstn"},   64'(cpu_rstn),   64'd0);
        check_val({pfx, "_cpu_run"},    64'(cpu_run),    64'd0);
        check_val({pfx, "_reg_sel"},    64'(reg_sel),    64'd0);
        check_val({pfx, "_dump_valid"}, 64'(dump_valid), 64'd0);
        check_val({pfx, "_dump_idx"},   64'(dump_idx),   64'd0);
        check_val({pfx, "_dump_data"},  64'(dump_data),  64'd0);
        check_val({pfx, "_cycle_cnt"},  64'(cycle_cnt),  64'd0);
        check_val({pfx, "_busy"},       64'(busy),       64'd0);
        check_val({pfx, "_done"},       64'(done),       64'd0);
        check_val({pfx, "_halt_cause"}, 64'(halt_cause), 64'd0);
    endtask

    task automatic launch(input logic [31:0] m, input logic e, input logic [31:0] a);
        start      = 1'b1;
        max_cycles = m;
        bp_en      = e;
        bp_addr    = a;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Follows one sequence cycle by cycle until DONE, an injected reset, or the budget runs out.
    task automatic watch(input bit abort_on_bp, input bit bp_chk, input int stall_idx,
                         input int stall_len, input int rst_idx, input int start_at);
        int exp_idx;
        bit fin;
        bit started;
        exp_idx   = 0;
        fin       = 1'b0;
        started   = 1'b0;
        rstn_low  = 0;
        run_cyc   = 0;
        beats     = 0;
        stall_cnt = 0;
        bp_seen   = 0;
        rst_hit   = 0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                if (busy && !cpu_rstn) rstn_low++;
                if (cpu_run) run_cyc++;
                abort = abort_on_bp && cpu_rstn && (cpu_pc == bp_addr);
                if (start_at > 0 && !started && cpu_run && run_cyc == start_at) begin
                    start      = 1'b1;
                    max_cycles = 32'd3;
                    started    = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (bp_chk && bp_seen == 0 && cpu_rstn && busy && cpu_pc == bp_addr) begin
                    check_val("bp_cycle_run_low", 64'(cpu_run), 64'd0);
                    bp_seen = 1;
                end
                if (rst_idx >= 0 && dump_valid && int'(dump_idx) == rst_idx) begin
                    rst = 1'b1;
                    #1;
                    check_reset_outputs("midscan_rst");
                    rst_hit = 1;
                    fin     = 1'b1;
                end else begin
                    if (dump_valid && int'(dump_idx) == stall_idx && stall_cnt < stall_len) begin
                        dump_ready = 1'b0;
                        check_val("stall_idx", 64'(dump_idx), 64'(stall_idx));
                        check_val("stall_data", 64'(dump_data), 64'(reg_val(seed, 5'(stall_idx))));
                        stall_cnt++;
                    end else begin
                        dump_ready = 1'b1;
                    end
                    if (dump_valid && dump_ready) begin
                        check_val("beat_idx", 64'(dump_idx), 64'(exp_idx));
                        check_val("beat_data", 64'(dump_data), 64'(reg_val(seed, 5'(exp_idx))));
                        exp_idx++;
                        beats++;
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (!fin) check_val("watch_timeout", 64'd0, 64'd1);
        abort      = 1'b0;
        start      = 1'b0;
        dump_ready = 1'b1;
    endtask

    task automatic check_full(input string pfx, input int runs, input logic [1:0] cause);
        check_val({pfx, "_rstn_low"},   64'(rstn_low),   64'd3);
        check_val({pfx, "_run_cycles"}, 64'(run_cyc),    64'(runs));
        check_val({pfx, "_cycle_cnt"},  64'(cycle_cnt),  64'(runs));
        check_val({pfx, "_halt_cause"}, 64'(halt_cause), 64'(cause));
        check_val({pfx, "_beats"},      64'(beats),      64'd32);
        check_val({pfx, "_done"},       64'(done),       64'd1);
        check_val({pfx, "_busy"},       64'(busy),       64'd0);
        check_val({pfx, "_cpu_rstn"},   64'(cpu_rstn),   64'd1);
        check_val({pfx, "_cpu_run"},    64'(cpu_run),    64'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        max_cycles = 32'd0;
        bp_en      = 1'b0;
        bp_addr    = 32'd0;
        dump_ready = 1'b1;
        seed       = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_cpu_rstn", 64'(cpu_rstn), 64'd0);

        // cycle limit of 10
        seed = 8'h21;
        launch(32'd10, 1'b0, 32'd0);
        check_val("t1_busy_after_start", 64'(busy), 64'd1);
        check_val("t1_cnt_cleared", 64'(cycle_cnt), 64'd0);
        watch(1'b0, 1'b0, -1, 0, -1, 0);
        check_full("t1", 10, 2'd1);

        // restart from DONE with a breakpoint at 0x8 and no limit
        seed = 8'h32;
        launch(32'd0, 1'b1, 32'h0000_0008);
        check_val("t2_restart_busy", 64'(busy), 64'd1);
        check_val("t2_restart_done", 64'(done), 64'd0);
        check_val("t2_restart_rstn", 64'(cpu_rstn), 64'd0);
        check_val("t2_restart_cause", 64'(halt_cause), 64'd0);
        check_val("t2_restart_cnt", 64'(cycle_cnt), 64'd0);
        watch(1'b0, 1'b1, -1, 0, -1, 0);
        check_val("t2_bp_seen", 64'(bp_seen), 64'd1);
        check_val("t2_pc_held", 64'(cpu_pc), 64'h8);
        check_full("t2", 2, 2'd2);

        // abort in the same cycle as the breakpoint match
        seed = 8'h43;
        launch(32'd0, 1'b1, 32'h0000_0008);
        watch(1'b1, 1'b1, -1, 0, -1, 0);
        check_val("t3_bp_seen", 64'(bp_seen), 64'd1);
        check_full("t3", 2, 2'd3);

        // sink stalls five cycles on beat 7
        seed = 8'h54;
        launch(32'd4, 1'b0, 32'd0);
        watch(1'b0, 1'b0, 7, 5, -1, 0);
        check_val("t4_stall_cycles", 64'(stall_cnt), 64'd5);
        check_full("t4", 4, 2'd1);

        // reset while beat 12 is offered, then a clean sequence from IDLE
        seed = 8'h65;
        launch(32'd3, 1'b0, 32'd0);
        watch(1'b0, 1'b0, -1, 0, 12, 0);
        check_val("t5_rst_reached", 64'(rst_hit), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("t5_idle_busy", 64'(busy), 64'd0);
        check_val("t5_idle_rstn", 64'(cpu_rstn), 64'd0);
        launch(32'd6, 1'b0, 32'd0);
        watch(1'b0, 1'b0, -1, 0, -1, 0);
        check_full("t5", 6, 2'd1);

        // start pulsed mid-run (with a new limit on the bus) must be ignored
        seed = 8'h76;
        launch(32'd20, 1'b0, 32'd0);
        watch(1'b0, 1'b0, -1, 0, -1, 3);
        check_full("t6", 20, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
